fifo_ctrl: RTL and testbench

- Sequencing stage directly upstream of the team's dual-port synchronous memory.
- Drives that memory's write/read strobes and its two addresses to turn it into a first-in-first-out queue.
- Exposes valid/ready handshakes on a push side and a pop side.
- Absorbs the memory's one-cycle registered read latency so the pop side sees a clean stream.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/mod_counter.sv | 34 +++
 rtl/fifo_ctrl.sv | 96 +++++++++
 tb/tb_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and pointer helper for the FIFO controller
//                that sequences a dual-port synchronous memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_default_data_w   = 8;
    localparam int c_default_mem_size = 6;

    // Increment a pointer and wrap from size-1 back to 0.
    // Modulus need not be a power of two.
    function automatic int next_ptr(input int ptr, input int size);
        return (ptr >= size - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Enable-gated modulo-N up counter used as a FIFO pointer.
//                Its value never leaves the range 0..MODULUS-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;

    // Advance by one on each enabled cycle, wrapping at MODULUS.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= WIDTH'(next_ptr(int'(r_value), MODULUS));
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Turns an external dual-port synchronous memory into a FIFO.
//                Valid/ready push and pop sides. The memory's one-cycle read
//                latency is absorbed by issuing a read as soon as the output
//                slot is free or being emptied. count excludes the entry
//                currently presented on out_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = c_default_data_w,
    parameter int MEM_SIZE  = c_default_mem_size,
    parameter int ADDR_SIZE = $clog2(MEM_SIZE),
    parameter int CNT_W     = $clog2(MEM_SIZE + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [ADDR_SIZE-1:0] mem_addr_w,
    output logic [ADDR_SIZE-1:0] mem_addr_r,
    output logic [DATA_W-1:0]    mem_datain,
    input  logic [DATA_W-1:0]    mem_dataout,
    output logic [CNT_W-1:0]     count
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(MEM_SIZE);

    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic             w_in_ready;
    logic             w_push;
    logic             w_issue;

    // in_ready depends on registered occupancy only, so there is no
    // combinational path from out_ready back to the producer.
    assign w_in_ready = (r_count != c_full);
    assign w_push     = in_valid & w_in_ready;
    // Read the next entry whenever memory holds one and the output slot is
    // empty or being consumed this cycle.
    assign w_issue    = (r_count != '0) & (~r_out_valid | out_ready);

    mod_counter #(
        .WIDTH   (ADDR_SIZE),
        .MODULUS (MEM_SIZE)
    ) u_wr_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_push),
        .o_value (mem_addr_w)
    );

    mod_counter #(
        .WIDTH   (ADDR_SIZE),
        .MODULUS (MEM_SIZE)
    ) u_rd_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_issue),
        .o_value (mem_addr_r)
    );

    // Track memory occupancy and whether the memory output holds a live entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push && !w_issue) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_issue) begin
                r_count <= r_count - CNT_W'(1);
            end
            r_out_valid <= w_issue | (r_out_valid & ~out_ready);
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = mem_dataout;
    assign mem_write  = w_push;
    assign mem_read   = w_issue;
    assign mem_datain = in_data;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Directed self-checking bench for fifo_ctrl with a behavioural
//                dual-port registered-read memory alongside it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int c_data_w   = 8;
    localparam int c_mem_size = 6;
    localparam int c_addr_w   = 3;
    localparam int c_cnt_w    = 3;

    logic                clk;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [c_data_w-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [c_data_w-1:0] out_data;
    logic                mem_write;
    logic                mem_read;
    logic [c_addr_w-1:0] mem_addr_w;
    logic [c_addr_w-1:0] mem_addr_r;
    logic [c_data_w-1:0] mem_datain;
    logic [c_data_w-1:0] mem_dataout;
    logic [c_cnt_w-1:0]  count;

    fifo_ctrl #(
        .DATA_W   (c_data_w),
        .MEM_SIZE (c_mem_size)
    ) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_addr_w  (mem_addr_w),
        .mem_addr_r  (mem_addr_r),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port memory with registered read data.
    logic [c_data_w-1:0] mem [0:7];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr_w] <= mem_datain;
        if (mem_read)  mem_dataout     <= mem[mem_addr_r];
    end

    int total = 0;
    int bad   = 0;
    logic [c_data_w-1:0] exp_q[$];
    int  m_wp = 0;
    int  m_rp = 0;
    bit  last_push;
    bit  last_pop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle from the negedge phase: check the transfer that is about
    // to happen against the model, then advance to the next negedge.
    task automatic step();
        #1;
        last_push = in_valid && in_ready;
        last_pop  = out_valid && out_ready;
        if (last_push) begin
            chk("wr_strobe", mem_write, 1);
            chk("wr_addr", mem_addr_w, m_wp);
            chk("wr_data", mem_datain, in_data);
            exp_q.push_back(in_data);
            m_wp = (m_wp == c_mem_size - 1) ? 0 : m_wp + 1;
        end
        if (mem_read) begin
            chk("rd_addr", mem_addr_r, m_rp);
            m_rp = (m_rp == c_mem_size - 1) ? 0 : m_rp + 1;
        end
        if (last_pop) begin
            if (exp_q.size() == 0) chk("pop_nonempty", 32'(exp_q.size()), 1);
            else                   chk("pop_data", out_data, exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        chk({tag, "_count"}, count, 0);
        chk({tag, "_ovalid"}, out_valid, 0);
        chk({tag, "_qempty"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int pushed;
        int cyc;
        int pops;
        logic [c_data_w-1:0] held;
        bit pat [4];

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        #1;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_inready", in_ready, 1);
        chk("rst_addr_w", mem_addr_w, 0);
        chk("rst_addr_r", mem_addr_r, 0);

        // Basic order and push-to-pop latency
        in_valid = 1'b1; in_data = 8'h11; step();
        in_data = 8'h22; #1;
        chk("lat_issue", mem_read, 1);
        chk("lat_ovalid_lo", out_valid, 0);
        step();
        chk("lat_ovalid_hi", out_valid, 1);
        in_data = 8'h33; step();
        in_valid = 1'b0; step();
        chk("basic_count", count, 2);
        chk("basic_ovalid", out_valid, 1);
        chk("basic_head", out_data, 8'h11);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("basic_stream_ovalid", out_valid, 1);
            step();
        end
        chk("basic_end_count", count, 0);
        chk("basic_end_ovalid", out_valid, 0);

        // Fill to full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int d = 1; d <= 7; d++) begin
            in_data = 8'(d);
            #1;
            chk("fill_ready", in_ready, 1);
            step();
        end
        in_data = 8'h08;
        #1;
        chk("full_count", count, 6);
        chk("full_inready", in_ready, 0);
        chk("full_nowrite", mem_write, 0);
        chk("full_head", out_data, 8'h01);
        step();
        chk("full_nowrite2", mem_write, 0);
        out_ready = 1'b1;
        #1;
        chk("full_still_blocked", in_ready, 0);
        step();
        chk("full_release", in_ready, 1);
        drain("fill");

        // Wrap-around with random gaps
        pushed = 0;
        cyc    = 0;
        while ((pushed < 20 || exp_q.size() != 0 || out_valid) && cyc < 400) begin
            in_valid  = (pushed < 20) && ($urandom_range(0, 1) == 1);
            in_data   = 8'(8'h40 + pushed);
            out_ready = ($urandom_range(0, 1) == 1);
            step();
            if (last_push) pushed++;
            cyc++;
        end
        chk("wrap_pushed", pushed, 20);
        chk("wrap_qempty", 32'(exp_q.size()), 0);
        drain("wrap");

        // Streaming after a two-entry prefill: one in memory, one presented
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h80; step();
        in_data   = 8'h81; step();
        in_valid  = 1'b0; step();
        chk("stream_pre_count", count, 1);
        chk("stream_pre_ovalid", out_valid, 1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 30; i++) begin
            in_data = 8'(8'h90 + i);
            step();
            if (last_pop && last_push) pops++;
            if (i == 10 || i == 29) chk("stream_count", count, 1);
        end
        chk("stream_transfers", pops, 30);
        drain("stream");

        // Back-pressure: out_ready 1,0,0,1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1; step();
        in_data   = 8'hA2; step();
        in_data   = 8'hA3; step();
        in_valid  = 1'b0; step();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            out_ready = pat[i];
            #1;
            chk("bp_ovalid", out_valid, 1);
            if (!pat[i]) begin
                chk("bp_noread", mem_read, 0);
                held = out_data;
                step();
                chk("bp_hold", out_data, held);
            end else begin
                step();
            end
        end
        drain("bp");

        // Reset mid-flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hC0 + i);
            step();
        end
        in_valid = 1'b0; step();
        chk("mid_count", count, 4);
        chk("mid_ovalid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_addr_w", mem_addr_w, 0);
        chk("mid_rst_addr_r", mem_addr_r, 0);
        exp_q.delete();
        m_wp = 0;
        m_rp = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        chk("mid_after_ovalid", out_valid, 1);
        chk("mid_after_data", out_data, 8'hAA);
        drain("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
